// File: rtl/fp_mac_pkg.sv
// Shared types and width helpers for the streaming fixed-point MAC.
// Imported by fp_mac_stream and fp_quant_rs.
package fp_mac_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    HOLD
  } state_t;

  // Guard bits cover lane summation and the longest vector, so the accumulator never wraps.
  function automatic int acc_width(input int in_w, input int lanes, input int max_beats);
    return 2 * in_w + $clog2(lanes) + $clog2(max_beats);
  endfunction

  function automatic int shift_amt(input int in_frac_w, input int out_frac_w);
    return 2 * in_frac_w - out_frac_w;
  endfunction

endpackage

// File: rtl/fp_quant_rs.sv
// Combinational round-half-up and saturate from the wide accumulator
// down to the output format. The shift amount must be at least 1.
module fp_quant_rs
  import fp_mac_pkg::*;
#(
  parameter int ACC_W = 38,
  parameter int OUT_W = 16,
  parameter int SH    = 8
) (
  input  logic [ACC_W-1:0] din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SH - 1);

  logic signed [ACC_W:0]         rounded;
  logic signed [ACC_W:0]         shifted;
  logic        [ACC_W-OUT_W+1:0] upper;

  // One extra bit absorbs the rounding increment; in range means every bit above the output sign matches it.
  always_comb begin
    rounded = {din[ACC_W-1], din} + HALF;
    shifted = rounded >>> SH;
    upper   = shifted[ACC_W:OUT_W-1];
    sat     = !((&upper) || !(|upper));
    if (sat) begin
      dout = shifted[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fp_mac_stream.sv
// Streaming signed fixed-point dot product: multiply, lane-sum, accumulate
// across beats, then emit one rounded and saturated result per vector.
module fp_mac_stream
  import fp_mac_pkg::*;
#(
  parameter int IN_INT_W   = 8,
  parameter int IN_FRAC_W  = 8,
  parameter int OUT_INT_W  = 8,
  parameter int OUT_FRAC_W = 8,
  parameter int LANES      = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*(IN_INT_W+IN_FRAC_W)-1:0]  in_a,
  input  logic [LANES*(IN_INT_W+IN_FRAC_W)-1:0]  in_b,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_INT_W+OUT_FRAC_W-1:0]        out_data,
  output logic                                   out_sat,
  output logic                                   out_trunc
);

  localparam int IN_W   = IN_INT_W + IN_FRAC_W;
  localparam int OUT_W  = OUT_INT_W + OUT_FRAC_W;
  localparam int PROD_W = 2 * IN_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int ACC_W  = acc_width(IN_W, LANES, MAX_BEATS);
  localparam int SH     = shift_amt(IN_FRAC_W, OUT_FRAC_W);
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);

  state_t state, state_next;

  logic                     accept, at_max, beat_last, flush_done;
  logic signed [PROD_W-1:0] prod    [LANES];
  logic signed [PROD_W-1:0] s1_prod [LANES];
  logic                     s1_last, s2_last;
  logic signed [SUM_W-1:0]  lane_sum, s2_sum;
  logic signed [ACC_W-1:0]  acc, total;
  logic        [CNT_W-1:0]  beat_cnt;
  logic                     trunc_pend;
  logic        [OUT_W-1:0]  q_data;
  logic                     q_sat;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign at_max     = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign beat_last  = in_last || at_max;
  assign flush_done = (state == FLUSH) && s2_last;
  assign total      = acc + ACC_W'(s2_sum);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PROD_W'($signed(in_a[IN_W*k +: IN_W])) * PROD_W'($signed(in_b[IN_W*k +: IN_W]));
    end
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_W'(s1_prod[k]);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && beat_last) state_next = FLUSH;
      FLUSH:   if (s2_last)             state_next = HOLD;
      HOLD:    if (out_ready)           state_next = ACCUM;
      default:                          state_next = ACCUM;
    endcase
  end

  fp_quant_rs #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SH    (SH)
  ) u_quant (
    .din  (total),
    .dout (q_data),
    .sat  (q_sat)
  );

  // Unaccepted cycles load zero products, so stalls flow through as bubbles that add nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      s1_last    <= 1'b0;
      s2_last    <= 1'b0;
      s2_sum     <= '0;
      acc        <= '0;
      beat_cnt   <= '0;
      trunc_pend <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      out_trunc  <= 1'b0;
      for (int k = 0; k < LANES; k++) s1_prod[k] <= '0;
    end else begin
      state <= state_next;
      for (int k = 0; k < LANES; k++) s1_prod[k] <= accept ? prod[k] : '0;
      s1_last <= accept && beat_last;
      s2_sum  <= lane_sum;
      s2_last <= s1_last;
      if (accept) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
        if (beat_last) trunc_pend <= at_max && !in_last;
      end
      if (flush_done) begin
        acc       <= '0;
        out_data  <= q_data;
        out_sat   <= q_sat;
        out_trunc <= trunc_pend;
      end else begin
        acc <= total;
      end
    end
  end

endmodule

// File: tb/tb_fp_mac_stream.sv
// Directed self-checking bench for fp_mac_stream in its default Q8.8, four-lane setup.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fp_mac_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_trunc;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mac_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                               input logic [15:0] a3, input logic [15:0] b0, input logic [15:0] b1,
                               input logic [15:0] b2, input logic [15:0] b3, input logic last);
    in_a     = {a3, a2, a1, a0};
    in_b     = {b3, b2, b1, b0};
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic waitResult(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consumeResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] data, input logic sat, input logic trunc);
    checkOutput({tag, "_data"},  {16'd0, out_data},  {16'd0, data});
    checkOutput({tag, "_sat"},   {31'd0, out_sat},   {31'd0, sat});
    checkOutput({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, trunc});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkResult("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single beat: 1*1 + 2*1 + (-1)*1 + 0.5*2 = 3.0, visible three cycles after acceptance
    applyStimulus(16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 1'b1);
    @(negedge clk);
    idleInputs();
    checkOutput("single_t1_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("single_t1_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("single_t2_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("single_t3_valid", {31'd0, out_valid}, 32'd1);
    checkResult("single", 16'h0300, 1'b0, 1'b0);
    consumeResult("single");

    // Three beats of 4.0 with idle gaps between them
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, i == 2);
      @(negedge clk);
      idleInputs();
      if (i < 2) repeat (2) @(negedge clk);
    end
    waitResult("three");
    checkResult("three", 16'h0C00, 1'b0, 1'b0);
    consumeResult("three");

    applyStimulus(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    @(negedge clk);
    idleInputs();
    waitResult("sat_neg");
    checkResult("sat_neg", 16'h8000, 1'b1, 1'b0);
    consumeResult("sat_neg");

    applyStimulus(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    idleInputs();
    waitResult("round_up");
    checkResult("round_up", 16'h0001, 1'b0, 1'b0);
    consumeResult("round_up");

    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    idleInputs();
    waitResult("round_neg");
    checkResult("round_neg", 16'h0000, 1'b0, 1'b0);
    consumeResult("round_neg");

    // Positive saturation, then hold the result under backpressure while junk beats are offered
    applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    @(negedge clk);
    idleInputs();
    waitResult("sat_pos");
    checkResult("sat_pos", 16'h7FFF, 1'b1, 1'b0);
    applyStimulus(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_data", {16'd0, out_data}, 32'h7FFF);
      checkOutput("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    idleInputs();
    consumeResult("hold");

    // Sixteen back-to-back beats without in_last are force-ended and flagged
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
    end
    checkOutput("trunc_ready_drop", {31'd0, in_ready}, 32'd0);
    idleInputs();
    waitResult("trunc");
    checkResult("trunc", 16'h1000, 1'b0, 1'b1);
    consumeResult("trunc");

    // Reset while flushing discards the vector entirely
    applyStimulus(16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    idleInputs();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    checkResult("rst_mid", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_after_valid", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    idleInputs();
    waitResult("post_rst");
    checkResult("post_rst", 16'h0100, 1'b0, 1'b0);
    consumeResult("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
